// File: rtl/shift_cmd_ctrl.sv
// shift_cmd_ctrl
//   Command sequencer plus a 16-entry operand register file. It feeds a
//   registered left shifter that has one cycle of latency, and it writes the
//   shifter result back into the register file.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is high only in IDLE. While cmd_ready
//   is low, the sender keeps cmd_valid asserted and cmd_* are ignored.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_src/amt/dst     source index, shift amount, destination index
//   wr_en/addr/data     host write port (any state, any edge)
//   rd_addr/rd_data     combinational host read port
//   sh_a, sh_shift      registered operand and amount to the shifter
//   sh_r                shifter result, valid while in WAIT
//   busy                high in ISSUE and WAIT
//   done                one-cycle pulse in the cycle after writeback
//   dbg_state           current FSM state (0=IDLE, 1=ISSUE, 2=WAIT)
module shift_cmd_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_src,
  input  logic [3:0]       cmd_amt,
  input  logic [3:0]       cmd_dst,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] sh_a,
  output logic [3:0]       sh_shift,
  input  logic [WIDTH-1:0] sh_r,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_sh_a;
  logic [3:0]       r_sh_shift;
  logic [3:0]       r_dst;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sh_a     <= '0;
      r_sh_shift <= '0;
      r_dst      <= '0;
      r_done     <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;

      // The host write comes first. In WAIT, a writeback to the same index
      // comes later in this block, so it overrides the host write.
      if (wr_en) begin
        r_regs[wr_addr] <= wr_data;
      end

      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // This reads the pre-edge register value. A host write on this
            // same edge is therefore not seen by the command.
            r_sh_a     <= r_regs[cmd_src];
            r_sh_shift <= cmd_amt;
            r_dst      <= cmd_dst;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The shifter captures sh_a/sh_shift at this edge.
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_regs[r_dst] <= sh_r;
          r_done        <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = r_done;
  assign sh_a      = r_sh_a;
  assign sh_shift  = r_sh_shift;
  assign rd_data   = r_regs[rd_addr];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_cmd_ctrl.sv
// Bench for shift_cmd_ctrl. The bench provides a registered left shifter.
// Expected behaviour comes from a transaction-level model: a register array,
// one pending-command record and an edge countdown to writeback.
module tb_shift_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_src, cmd_amt, cmd_dst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] sh_a;
  logic [3:0]  sh_shift;
  logic [15:0] sh_r;
  logic        busy, done;
  logic [1:0]  dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  shift_cmd_ctrl #(.WIDTH(16), .NREG(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_amt(cmd_amt), .cmd_dst(cmd_dst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .sh_a(sh_a), .sh_shift(sh_shift), .sh_r(sh_r),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Registered shifter with no reset, one cycle of latency.
  initial sh_r = 16'h0;
  always @(posedge clk) sh_r <= sh_a << sh_shift;

  // ---------------- scoreboard / report ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_regs [16];
  bit          m_pend;
  int          m_cnt;     // edges remaining until writeback
  logic [3:0]  m_dst;
  logic [15:0] m_res;
  logic [15:0] m_sha;
  logic [3:0]  m_shs;
  bit          m_done;
  bit          m_acc;
  int          m_edge;
  int          acc_edges[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_pend = 0; m_cnt = 0; m_dst = 0; m_res = 0;
    m_sha = 0; m_shs = 0; m_done = 0; m_acc = 0;
  endtask

  // Advance the model across the next rising edge, using the current inputs.
  task automatic model_step();
    logic [31:0] wide;
    logic [15:0] op;
    bit          do_wb;
    m_edge++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_acc  = cmd_valid && !m_pend;
    do_wb  = m_pend && (m_cnt == 1);
    op     = m_regs[cmd_src];              // pre-edge value
    if (wr_en) m_regs[wr_addr] = wr_data;
    m_done = 0;
    if (do_wb) begin
      m_regs[m_dst] = m_res;               // writeback beats host write
      m_pend = 0;
      m_done = 1;
    end else if (m_pend) begin
      m_cnt--;
    end
    if (m_acc) begin
      wide   = {16'h0, op} << cmd_amt;
      m_res  = wide[15:0];
      m_dst  = cmd_dst;
      m_sha  = op;
      m_shs  = cmd_amt;
      m_pend = 1;
      m_cnt  = 2;
      acc_edges.push_back(m_edge);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: step model, pass the edge, compare all outputs on the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("cmd_ready", cmd_ready, !m_pend);
    chk("busy", busy, m_pend);
    chk("done", done, m_done);
    chk("sh_a", sh_a, m_sha);
    chk("sh_shift", sh_shift, m_shs);
    chk("rd_data", rd_data, m_regs[rd_addr]);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Present a command, wait (bounded) for acceptance, then run to the done cycle.
  task automatic issue(input logic [3:0] s, input logic [3:0] amt, input logic [3:0] d);
    bit ok = 0;
    cmd_valid = 1; cmd_src = s; cmd_amt = amt; cmd_dst = d;
    for (int k = 0; k < 8 && !ok; k++) begin
      tick();
      ok = m_acc;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    cmd_valid = 0;
    tick();
    tick();
    chk("issue_done", done, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0; cmd_valid = 0; cmd_src = 0; cmd_amt = 0; cmd_dst = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; m_edge = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sh_a", sh_a, 0);
    rst_n = 1;
    tick();

    // Reset while in WAIT, with a command that targets r5.
    host_wr(4'd5, 16'h1234);
    cmd_valid = 1; cmd_src = 5; cmd_amt = 1; cmd_dst = 5;
    tick();
    chk("rstw_acc", m_acc, 1);
    cmd_valid = 0;
    tick();
    chk("rstw_in_wait", dbg_state, 2);
    rst_n = 0;
    #1;
    chk("rstw_ready", cmd_ready, 1);
    chk("rstw_busy", busy, 0);
    chk("rstw_done", done, 0);
    model_reset();
    tick();
    rst_n = 1;
    tick();
    chk("rstw_no_done", done, 0);
    read_chk("rstw_r5", 4'd5, 16'h0000);
    for (int i = 0; i < 16; i++) read_chk("rstw_all", i[3:0], 16'h0000);

    // Basic shift.
    host_wr(4'd1, 16'h00FF);
    issue(4'd1, 4'd4, 4'd2);
    read_chk("basic_r2", 4'd2, 16'h0FF0);
    read_chk("basic_r1", 4'd1, 16'h00FF);

    // Boundary shift amounts.
    host_wr(4'd3, 16'h0003);
    issue(4'd3, 4'd15, 4'd4);
    read_chk("amt15", 4'd4, 16'h8000);
    issue(4'd3, 4'd0, 4'd6);
    read_chk("amt0", 4'd6, 16'h0003);
    host_wr(4'd3, 16'hFFFF);
    issue(4'd3, 4'd13, 4'd11);
    read_chk("amt13", 4'd11, 16'hE000);

    // Back-to-back commands where cmd2 uses cmd1's result.
    host_wr(4'd1, 16'h0001);
    acc_edges.delete();
    cmd_valid = 1; cmd_src = 1; cmd_amt = 1; cmd_dst = 1;
    tick();
    cmd_src = 1; cmd_amt = 1; cmd_dst = 7;
    for (int k = 0; k < 8 && acc_edges.size() < 2; k++) tick();
    cmd_valid = 0;
    tick();
    tick();
    chk("b2b_count", acc_edges.size(), 2);
    if (acc_edges.size() == 2) chk("b2b_gap", acc_edges[1] - acc_edges[0], 3);
    read_chk("b2b_r1", 4'd1, 16'h0002);
    read_chk("b2b_r7", 4'd7, 16'h0004);

    // Host write to the same register on the writeback edge: writeback wins.
    host_wr(4'd12, 16'h0001);
    cmd_valid = 1; cmd_src = 12; cmd_amt = 4; cmd_dst = 8;
    tick();
    cmd_valid = 0;
    tick();
    wr_en = 1; wr_addr = 8; wr_data = 16'hAAAA;
    tick();
    wr_en = 0;
    read_chk("coll_same_r8", 4'd8, 16'h0010);
    // Host write to a different register on the writeback edge: both writes land.
    host_wr(4'd8, 16'h0000);
    cmd_valid = 1; cmd_src = 12; cmd_amt = 4; cmd_dst = 8;
    tick();
    cmd_valid = 0;
    tick();
    wr_en = 1; wr_addr = 9; wr_data = 16'hBBBB;
    tick();
    wr_en = 0;
    read_chk("coll_diff_r8", 4'd8, 16'h0010);
    read_chk("coll_diff_r9", 4'd9, 16'hBBBB);

    // Source register written after the command was accepted.
    host_wr(4'd2, 16'h0101);
    cmd_valid = 1; cmd_src = 2; cmd_amt = 8; cmd_dst = 10;
    tick();
    cmd_valid = 0;
    wr_en = 1; wr_addr = 2; wr_data = 16'hFFFF;
    tick();
    wr_en = 0;
    tick();
    read_chk("late_r10", 4'd10, 16'h0100);
    read_chk("late_r2", 4'd2, 16'hFFFF);

    // Random traffic checked against the model.
    for (int n = 0; n < 600; n++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_src   = 4'($urandom_range(0, 15));
      cmd_amt   = 4'($urandom_range(0, 15));
      cmd_dst   = 4'($urandom_range(0, 15));
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = 16'($urandom);
      rd_addr   = 4'($urandom_range(0, 15));
      tick();
    end
    cmd_valid = 0; wr_en = 0;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) read_chk("final_regs", i[3:0], m_regs[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
